// File: rtl/ascon_pkg.sv
// ============================================================================
// Module      : ascon_pkg
// Description : Shared constants, FSM encoding and word-level helpers for the
//               Ascon permutation controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ascon_pkg;

    localparam int MAX_ROUNDS = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Round constant for rc_idx 0..11; indices past the table yield zero.
    function automatic logic [7:0] rc_lookup(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'hf0;
            4'd1:    rc = 8'he1;
            4'd2:    rc = 8'hd2;
            4'd3:    rc = 8'hc3;
            4'd4:    rc = 8'hb4;
            4'd5:    rc = 8'ha5;
            4'd6:    rc = 8'h96;
            4'd7:    rc = 8'h87;
            4'd8:    rc = 8'h78;
            4'd9:    rc = 8'h69;
            4'd10:   rc = 8'h5a;
            4'd11:   rc = 8'h4b;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned r);
        return (x >> r) | (x << (64 - r));
    endfunction

    // Word layout {x0..x4} -> 64 five-bit columns, x0 at the column MSB.
    function automatic logic [319:0] interleave(input logic [319:0] s);
        logic [319:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            v[5*i +: 5] = {s[256+i], s[192+i], s[128+i], s[64+i], s[i]};
        end
        return v;
    endfunction

    function automatic logic [319:0] deinterleave(input logic [319:0] v);
        logic [319:0] s;
        s = '0;
        for (int i = 0; i < 64; i++) begin
            {s[256+i], s[192+i], s[128+i], s[64+i], s[i]} = v[5*i +: 5];
        end
        return s;
    endfunction

    function automatic logic [319:0] linear_layer(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        return {x0 ^ ror64(x0, 19) ^ ror64(x0, 28),
                x1 ^ ror64(x1, 61) ^ ror64(x1, 39),
                x2 ^ ror64(x2,  1) ^ ror64(x2,  6),
                x3 ^ ror64(x3, 10) ^ ror64(x3, 17),
                x4 ^ ror64(x4,  7) ^ ror64(x4, 41)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ascon_ps.sv
// ============================================================================
// Module      : ascon_ps
// Description : 320-bit Ascon substitution layer, 64 parallel 5-bit S-boxes on
//               an interleaved state (column bit 4 = x0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_ps (
    input  logic [319:0] i_state,
    output logic [319:0] o_state
);

    for (genvar gi = 0; gi < 64; gi++) begin : g_sbox
        logic w_a0, w_a1, w_a2, w_a3, w_a4;
        logic w_b0, w_b2, w_b4;
        logic w_c0, w_c1, w_c2, w_c3, w_c4;

        assign {w_a0, w_a1, w_a2, w_a3, w_a4} = i_state[5*gi +: 5];

        assign w_b0 = w_a0 ^ w_a4;
        assign w_b4 = w_a4 ^ w_a3;
        assign w_b2 = w_a2 ^ w_a1;

        // Chi-like nonlinear core followed by the output mixing
        assign w_c0 = w_b0 ^ (~w_a1 & w_b2);
        assign w_c1 = w_a1 ^ (~w_b2 & w_a3);
        assign w_c2 = w_b2 ^ (~w_a3 & w_b4);
        assign w_c3 = w_a3 ^ (~w_b4 & w_b0);
        assign w_c4 = w_b4 ^ (~w_b0 & w_a1);

        assign o_state[5*gi +: 5] = {w_c0 ^ w_c4, w_c1 ^ w_c0, ~w_c2, w_c3 ^ w_c2, w_c4};
    end

endmodule

`default_nettype wire

// File: rtl/ascon_perm_ctrl.sv
// ============================================================================
// Module      : ascon_perm_ctrl
// Description : Iterative Ascon p^n controller, one round per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_perm_ctrl #(
    parameter int MAX_ROUNDS = ascon_pkg::MAX_ROUNDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [3:0]   rounds_i,
    input  logic [319:0] state_i,
    output logic         ready_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [319:0] state_o
);

    import ascon_pkg::*;

    localparam logic [3:0] c_max_n = 4'(MAX_ROUNDS);

    fsm_t         r_fsm, w_fsm_nxt;
    logic [3:0]   r_cnt, w_cnt_nxt;
    logic [3:0]   r_rc_idx, w_rc_idx_nxt;
    logic [319:0] r_state, w_state_nxt;

    logic [3:0]   w_n;
    logic [319:0] w_pc, w_ps_out, w_round;

    // Round datapath: constant addition, substitution, linear diffusion
    assign w_pc = {r_state[319:136], r_state[135:128] ^ rc_lookup(r_rc_idx), r_state[127:0]};

    ascon_ps u_ps (
        .i_state (interleave(w_pc)),
        .o_state (w_ps_out)
    );

    assign w_round = linear_layer(deinterleave(w_ps_out));
    assign w_n     = (rounds_i > c_max_n) ? c_max_n : rounds_i;

    always_comb begin
        w_fsm_nxt    = r_fsm;
        w_cnt_nxt    = r_cnt;
        w_rc_idx_nxt = r_rc_idx;
        w_state_nxt  = r_state;
        case (r_fsm)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt  = state_i;
                    w_cnt_nxt    = w_n;
                    w_rc_idx_nxt = c_max_n - w_n;
                    w_fsm_nxt    = (w_n == 4'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                w_state_nxt  = w_round;
                w_cnt_nxt    = r_cnt - 4'd1;
                w_rc_idx_nxt = r_rc_idx + 4'd1;
                if (r_cnt == 4'd1) begin
                    w_fsm_nxt = DONE;
                end
            end
            DONE:    w_fsm_nxt = IDLE;
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm    <= IDLE;
            r_cnt    <= 4'd0;
            r_rc_idx <= 4'd0;
            r_state  <= '0;
        end else begin
            r_fsm    <= w_fsm_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rc_idx <= w_rc_idx_nxt;
            r_state  <= w_state_nxt;
        end
    end

    assign ready_o = (r_fsm == IDLE);
    assign busy_o  = (r_fsm == RUN) || (r_fsm == DONE);
    assign done_o  = (r_fsm == DONE);
    assign state_o = r_state;

endmodule

`default_nettype wire

// File: tb/tb_ascon_perm_ctrl.sv
// ============================================================================
// Module      : tb_ascon_perm_ctrl
// Description : Self-checking bench for ascon_perm_ctrl against a word-level
//               Ascon reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascon_perm_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [3:0]   rounds_i;
    logic [319:0] state_i;
    logic         ready_o, busy_o, done_o;
    logic [319:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    ascon_perm_ctrl #(.MAX_ROUNDS(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .rounds_i (rounds_i),
        .state_i  (state_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    logic [4:0] sbox [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                              5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                              5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                              5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    int rot_a [5] = '{19, 61, 1, 10, 7};
    int rot_b [5] = '{28, 39, 6, 17, 41};

    function automatic logic [63:0] rr(input logic [63:0] x, input int r);
        logic [127:0] d;
        d = {x, x} >> r;
        return d[63:0];
    endfunction

    // Reference: round r uses constant ((15-r)<<4)|r, rounds 12-n .. 11
    function automatic logic [319:0] model_perm(input logic [319:0] s, input int rounds);
        logic [63:0] x [5];
        logic [4:0]  col;
        int          n;
        for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
        n = (rounds > 12) ? 12 : rounds;
        for (int r = 12 - n; r < 12; r++) begin
            x[2] = x[2] ^ 64'((15 - r) * 16 + r);
            for (int i = 0; i < 64; i++) begin
                col = sbox[{x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]}];
                for (int w = 0; w < 5; w++) x[w][i] = col[4 - w];
            end
            for (int w = 0; w < 5; w++) x[w] = x[w] ^ rr(x[w], rot_a[w]) ^ rr(x[w], rot_b[w]);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] s;
        for (int w = 0; w < 10; w++) s[32*w +: 32] = $urandom;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) for done_o, counting cycles and any ready_o seen high
    task automatic wait_done(output int lat, output int ready_hi);
        lat = 0;
        ready_hi = 0;
        while (!done_o && lat < 30) begin
            if (ready_o) ready_hi++;
            tick();
            lat++;
        end
    endtask

    task automatic run_check(input string name, input logic [3:0] rounds,
                             input logic [319:0] st, input logic [319:0] exp, input int exp_lat);
        int lat, rdy;
        start_i  = 1'b1;
        rounds_i = rounds;
        state_i  = st;
        tick();
        start_i  = 1'b0;
        state_i  = rand_state();
        rounds_i = 4'(($urandom));
        wait_done(lat, rdy);
        chk_i({name, " latency"}, lat, exp_lat);
        chk_i({name, " ready low while busy"}, rdy, 0);
        chk_w({name, " state"}, state_o, exp);
        tick();
        chk_i({name, " done one cycle"}, int'(done_o), 0);
        chk_w({name, " state held"}, state_o, exp);
    endtask

    typedef struct {
        string        name;
        logic [3:0]   rounds;
        logic [319:0] st;
        logic [319:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [319:0] rs, a, b;
        int lat, rdy, spurious;

        rs = rand_state();
        vecs[0] = '{"r0_pattern", 4'd0, {5{64'h0123456789abcdef}}, {5{64'h0123456789abcdef}}, 0};
        vecs[1] = '{"r12_zero",   4'd12, '0, model_perm('0, 12), 12};
        vecs[2] = '{"r12_rand",   4'd12, rs, model_perm(rs, 12), 12};
        vecs[3] = '{"r8_zero",    4'd8,  '0, model_perm('0, 8), 8};
        vecs[4] = '{"r8_rand",    4'd8,  rs, model_perm(rs, 8), 8};
        vecs[5] = '{"r15_clamp",  4'd15, rs, model_perm(rs, 12), 12};
        vecs[6] = '{"r1_zero",    4'd1,  '0, model_perm('0, 1), 1};
        vecs[7] = '{"r13_clamp",  4'd13, '0, model_perm('0, 12), 12};

        rst = 1'b1;
        start_i = 1'b0;
        rounds_i = '0;
        state_i = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_i("reset ready", int'(ready_o), 1);
        chk_i("reset busy", int'(busy_o), 0);
        chk_i("reset done", int'(done_o), 0);
        chk_w("reset state", state_o, '0);

        for (int i = 0; i < 8; i++) begin
            run_check(vecs[i].name, vecs[i].rounds, vecs[i].st, vecs[i].exp, vecs[i].lat);
        end

        for (int i = 0; i < 12; i++) begin
            logic [3:0] r;
            r  = 4'($urandom_range(0, 15));
            rs = rand_state();
            run_check("random", r, rs, model_perm(rs, int'(r)), (r > 12) ? 12 : int'(r));
        end

        // start_i held high across a run; second run taken on first IDLE cycle
        a = rand_state();
        b = rand_state();
        start_i  = 1'b1;
        rounds_i = 4'd4;
        state_i  = a;
        tick();
        rounds_i = 4'd2;
        state_i  = b;
        wait_done(lat, rdy);
        chk_i("held latency", lat, 4);
        chk_i("held ready low", rdy + int'(ready_o), 0);
        chk_w("held first result", state_o, model_perm(a, 4));
        tick();
        chk_i("held idle ready", int'(ready_o), 1);
        chk_w("held result kept", state_o, model_perm(a, 4));
        tick();
        start_i = 1'b0;
        chk_i("held second accepted", int'(busy_o), 1);
        wait_done(lat, rdy);
        chk_i("held second latency", lat, 2);
        chk_w("held second result", state_o, model_perm(b, 2));
        tick();

        // Reset during the 5th RUN cycle of a 12-round run
        start_i  = 1'b1;
        rounds_i = 4'd12;
        state_i  = rand_state();
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk_i("pre-reset busy", int'(busy_o), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_i("midrun rst ready", int'(ready_o), 1);
        chk_i("midrun rst busy", int'(busy_o), 0);
        chk_i("midrun rst done", int'(done_o), 0);
        chk_w("midrun rst state", state_o, '0);
        spurious = 0;
        for (int i = 0; i < 15; i++) begin
            if (done_o) spurious++;
            tick();
        end
        chk_i("no done after rst", spurious, 0);

        // Reset wins over a simultaneous start
        rst = 1'b1;
        start_i = 1'b1;
        rounds_i = 4'd3;
        state_i = rand_state();
        tick();
        rst = 1'b0;
        start_i = 1'b0;
        chk_i("rst vs start ready", int'(ready_o), 1);
        chk_w("rst vs start state", state_o, '0);

        rs = rand_state();
        run_check("post-reset r12", 4'd12, rs, model_perm(rs, 12), 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
